// File: rtl/rr_arbiter4_if.sv
// rr_arbiter4_if: request/grant bundle between four requesters and the arbiter.
interface rr_arbiter4_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    modport master (output req, input gnt, gnt_idx, gnt_valid);
    modport slave  (input req, output gnt, gnt_idx, gnt_valid);
endinterface

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-way round-robin arbiter with bounded hold under contention.
module dec2to4 (
    input  logic [1:0] in,
    output logic [3:0] out
);
    assign out = 4'b0001 << in;
endmodule

module rr_arbiter4 #(
    parameter int MAX_HOLD = 8
) (
    input logic          clk,
    input logic          rst,
    rr_arbiter4_if.slave bus
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t     state, state_nx;
    logic [1:0] ptr, ptr_nx, idx, idx_nx, win;
    logic [7:0] cnt, cnt_nx;
    logic [3:0] own, elig;
    logic       found, load, at_max;

    // first set bit of m in the order p, p+1, p+2, p+3; msb flags a hit
    function automatic logic [2:0] pick(input logic [3:0] m, input logic [1:0] p);
        pick = 3'b000;
        for (int k = 3; k >= 0; k--)
            if (m[p + 2'(k)]) pick = {1'b1, p + 2'(k)};
    endfunction

    dec2to4 u_dec (.in(idx), .out(own));

    assign at_max = (cnt == 8'(MAX_HOLD - 1));

    always_comb begin
        state_nx = state;
        idx_nx = idx;
        ptr_nx = ptr;
        cnt_nx = cnt;
        load = 1'b0;
        elig = (state == GRANT) ? (bus.req & ~own) : bus.req;
        {found, win} = pick(elig, ptr);
        if (state == IDLE)
            load = found;
        else if (!bus.req[idx]) begin
            load = found;
            state_nx = found ? GRANT : IDLE;
        end else if (at_max && found)
            load = 1'b1;
        else
            cnt_nx = at_max ? cnt : cnt + 8'd1;
        if (load) begin
            state_nx = GRANT;
            idx_nx = win;
            ptr_nx = win + 2'd1;
            cnt_nx = 8'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr <= 2'd0;
            idx <= 2'd0;
            cnt <= 8'd0;
        end else begin
            state <= state_nx;
            ptr <= ptr_nx;
            idx <= idx_nx;
            cnt <= cnt_nx;
        end
    end

    assign bus.gnt_idx = idx;
    assign bus.gnt_valid = (state == GRANT);
    assign bus.gnt = own & {4{state == GRANT}};
endmodule

// File: tb/tb_rr_arbiter4.sv
// tb_rr_arbiter4: directed checks of round-robin order, preemption, wrap and async reset.
module tb_rr_arbiter4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    rr_arbiter4_if bus();
    rr_arbiter4 #(.MAX_HOLD(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] g, input logic [1:0] i, input logic v);
        checks++;
        assert ({bus.gnt, bus.gnt_idx, bus.gnt_valid} === {g, i, v})
        else begin
            errors++;
            $error("FAIL %s: got gnt=%b idx=%0d valid=%b, exp gnt=%b idx=%0d valid=%b",
                   tag, bus.gnt, bus.gnt_idx, bus.gnt_valid, g, i, v);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = 4'b0000;
        step();
        rst = 1'b0;
    endtask

    initial begin
        bus.req = 4'b0000;
        step();
        chk("reset", 4'b0000, 2'd0, 1'b0);
        rst = 1'b0;
        // single request and release
        bus.req = 4'b0100;
        step();
        chk("single_grant", 4'b0100, 2'd2, 1'b1);
        bus.req = 4'b0000;
        step();
        chk("single_release", 4'b0000, 2'd2, 1'b0);
        // round-robin handoffs without bubbles
        do_reset();
        bus.req = 4'b1111;
        step();
        chk("rr0", 4'b0001, 2'd0, 1'b1);
        bus.req = 4'b1110;
        step();
        chk("rr1", 4'b0010, 2'd1, 1'b1);
        bus.req = 4'b1101;
        step();
        chk("rr2", 4'b0100, 2'd2, 1'b1);
        bus.req = 4'b1011;
        step();
        chk("rr3", 4'b1000, 2'd3, 1'b1);
        bus.req = 4'b0111;
        step();
        chk("rr_wrap", 4'b0001, 2'd0, 1'b1);
        // preemption after MAX_HOLD=4 cycles
        do_reset();
        bus.req = 4'b0011;
        for (int n = 0; n < 9; n++) begin
            step();
            if (n >= 4 && n < 8) chk("preempt_b", 4'b0010, 2'd1, 1'b1);
            else chk("preempt_a", 4'b0001, 2'd0, 1'b1);
        end
        // no contention: unbounded hold, counter saturates
        do_reset();
        bus.req = 4'b1000;
        for (int n = 0; n < 20; n++) begin
            step();
            chk("solo_hold", 4'b1000, 2'd3, 1'b1);
        end
        checks++;
        assert (dut.cnt === 8'd3)
        else begin
            errors++;
            $error("FAIL cnt_sat: got %0d exp 3", dut.cnt);
        end
        // wrap-around pointer: owner 3 at max hold preempted to 0, then back to 3
        bus.req = 4'b1001;
        step();
        chk("wrap_to0", 4'b0001, 2'd0, 1'b1);
        bus.req = 4'b1000;
        step();
        chk("wrap_to3", 4'b1000, 2'd3, 1'b1);
        // asynchronous reset mid-grant
        do_reset();
        bus.req = 4'b0010;
        step();
        chk("pre_async", 4'b0010, 2'd1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_clear", 4'b0000, 2'd0, 1'b0);
        bus.req = 4'b1111;
        step();
        chk("rst_hold", 4'b0000, 2'd0, 1'b0);
        rst = 1'b0;
        step();
        chk("post_rst", 4'b0001, 2'd0, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-requester round-robin arbiter that shares a single resource selected through the team's 2-to-4 decoder. The arbiter computes a 2-bit winner index, drives it through the decoder to produce a one-hot grant, and holds the grant across cycles with a bounded hold time. It sits between four request sources and the shared resource's select/enable lines.

## Interface

**Parameters**
- `MAX_HOLD`, default 8: maximum consecutive cycles one requester keeps the grant while any other request is pending. Legal range is 1..255.

**Ports**
- `clk`, input, 1: sole clock; all state changes on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `req`, input, 4: request lines; `req[i]=1` means requester i wants the resource. Level-sensitive.
- `gnt`, output, 4: one-hot grant, equal to the decoder output of `gnt_idx` when `gnt_valid=1`, else `4'b0000`.
- `gnt_idx`, output, 2: index of the current grant holder.
- `gnt_valid`, output, 1: a grant is active.

## Operation

**State machine (2 states)**
- IDLE
  - `gnt_valid=0`, `gnt=0000`, `gnt_idx` holds its last value.
  - If any `req` bit is set, arbitrate, load the winner, clear `cnt`, and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT: owner = `gnt_idx`, one transition per edge, evaluated in this order:
  1. **Release.** If `req[owner]=0`:
     - other requests pending: arbitrate among them, load the new winner, clear `cnt`, stay in GRANT. This is a direct handoff with no idle bubble.
     - none pending: go to IDLE.
  2. **Preempt.** If `req[owner]=1`, `cnt==MAX_HOLD-1`, and any other `req` bit is set: arbitrate excluding the owner, load the winner, clear `cnt`.
  3. **Hold.** Otherwise keep the owner. `cnt` increments, saturating at `MAX_HOLD-1`.

**Arbitration**
- Internal 2-bit pointer `ptr`. The search order is `ptr, ptr+1, ptr+2, ptr+3` (mod 4); the first set eligible bit wins.
- On every new grant load, `ptr <= winner+1` (mod 4). Wrap-around: winner 3 sets `ptr=0`.
- Re-grant to the same index after a release is allowed only if it comes first in the search order.

**Width rules**
- `cnt` is 8 bits.
- `MAX_HOLD=1` means the owner is preempted after every cycle whenever contention exists.

**Decoder**
- Instantiated combinationally: in = `gnt_idx`, out ANDed with `gnt_valid` gives `gnt`.
- `gnt` is never multi-hot.

## Timing

**Reset**
- `rst` asserted (asynchronous, any time, including mid-grant) gives:
  - state = IDLE, `ptr=0`, `cnt=0`, `gnt_idx=00`, `gnt_valid=0`, `gnt=0000`.
  - These hold while `rst=1`.
- First arbitration happens on the first rising edge after `rst` deasserts.

**Latency**
- `req` rising in IDLE gives `gnt_valid`/`gnt` at the next edge (1 cycle).
- Handoff on release: the new `gnt` appears on the edge where the old owner's `req=0` is sampled. Grant is lost the same cycle and the next owner is granted, with no gap.

**Hold bound**
- Under contention, an owner holding `req` high keeps the grant for exactly `MAX_HOLD` cycles.
- Without contention, hold time is unbounded.

**Other rules**
- Simultaneous events: release takes priority over preempt.
- Outputs are registered; `gnt` depends only on registered state, with no combinational path from `req`.

## Test plan

1. **Reset then single request.** `rst` pulse, then `req=0100` → 1 cycle later `gnt=0100`, `gnt_idx=10`, `gnt_valid=1`. Drop `req` → next edge `gnt=0000`.
2. **Round-robin order.** From reset, `req=1111`, each owner drops `req` for one cycle after being granted, then re-raises it → grant sequence 0001, 0010, 0100, 1000, 0001 with no idle cycles.
3. **Preemption.** `MAX_HOLD=4`, `req=0011` held constant → `gnt=0001` for 4 cycles, `0010` for 4 cycles, then `0001` again.
4. **No contention.** `MAX_HOLD=4`, `req=1000` for 20 cycles → `gnt=1000` for all 20 cycles; `cnt` saturates at 3.
5. **Wrap-around pointer.** Grant 3, then `req=1001` → next grant goes to 0, then 3.
6. **Asynchronous reset mid-grant.** During `gnt=0010`, assert `rst` between edges → `gnt=0000` immediately. After release with `req=1111`, the first grant is `0001`.
